// File: rtl/hs_fifo_n.sv
// DEPTH-deep, WIDTH-wide FIFO with a four-phase follower on the write side
// (rr/ar) and a four-phase initiator on the read side (rw/aw).
module hs_fifo_n #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             rr,
  output logic             ar,
  output logic [WIDTH-1:0] dout,
  output logic             rw,
  input  logic             aw,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic       {W_IDLE, W_ACK}        wst_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_REL} rst_t;

  wst_t             wstate;
  rst_t             rstate;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             push, pop;

  // full/empty come from the registered count, so a write blocked by full
  // only proceeds on the edge after the pop that made room.
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign push  = (wstate == W_IDLE) && rr && !full;
  assign pop   = (rstate == R_REQ) && aw;

  always_ff @(posedge clk) begin
    if (reset && push) mem[wptr] <= din;
  end

  // Write side: one entry per rr pulse, din captured on the edge leaving W_IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wstate <= W_IDLE;
      ar     <= 1'b0;
      wptr   <= '0;
    end else begin
      case (wstate)
        W_IDLE: if (push) begin
          wptr   <= wptr + AW'(1);
          ar     <= 1'b1;
          wstate <= W_ACK;
        end
        W_ACK: if (!rr) begin
          ar     <= 1'b0;
          wstate <= W_IDLE;
        end
      endcase
    end
  end

  // Read side: the head entry stays counted until the follower acknowledges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rstate <= R_IDLE;
      rw     <= 1'b0;
      dout   <= '0;
      rptr   <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (!empty) begin
          dout   <= mem[rptr];
          rw     <= 1'b1;
          rstate <= R_REQ;
        end
        R_REQ: if (aw) begin
          rptr   <= rptr + AW'(1);
          rw     <= 1'b0;
          rstate <= R_REL;
        end
        R_REL: if (!aw) rstate <= R_IDLE;
        default: begin
          rw     <= 1'b0;
          rstate <= R_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) count <= '0;
    else        count <= count + CW'(push) - CW'(pop);
  end

endmodule
